// File: rtl/wb_mem_pkg.sv
// rtl/wb_mem_pkg.sv - shared encodings for the wait-stated data memory controller
package wb_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

endpackage

// File: rtl/wb_data_memory_ctrl_if.sv
// rtl/wb_data_memory_ctrl_if.sv - request/response bus between sequencer and data memory controller
interface wb_data_memory_ctrl_if #(
  parameter int DATAWIDTH_BUS = 32
);
  logic                     DataMemCtrl_Req_In;
  logic                     DataMemCtrl_WR_In;
  logic [1:0]               DataMemCtrl_Size_In;
  logic                     DataMemCtrl_Signed_In;
  logic [DATAWIDTH_BUS-1:0] DataMemCtrl_Address_In;
  logic [DATAWIDTH_BUS-1:0] DataMemCtrl_Data_In;
  logic [DATAWIDTH_BUS-1:0] DataMemCtrl_Data_Out;
  logic                     DataMemCtrl_Ack_Out;
  logic                     DataMemCtrl_Busy_Out;
  logic                     DataMemCtrl_Fault_Out;

  modport master (
    output DataMemCtrl_Req_In, DataMemCtrl_WR_In, DataMemCtrl_Size_In,
           DataMemCtrl_Signed_In, DataMemCtrl_Address_In, DataMemCtrl_Data_In,
    input  DataMemCtrl_Data_Out, DataMemCtrl_Ack_Out, DataMemCtrl_Busy_Out,
           DataMemCtrl_Fault_Out
  );

  modport slave (
    input  DataMemCtrl_Req_In, DataMemCtrl_WR_In, DataMemCtrl_Size_In,
           DataMemCtrl_Signed_In, DataMemCtrl_Address_In, DataMemCtrl_Data_In,
    output DataMemCtrl_Data_Out, DataMemCtrl_Ack_Out, DataMemCtrl_Busy_Out,
           DataMemCtrl_Fault_Out
  );
endinterface

// File: rtl/wb_mem_lane_align.sv
// rtl/wb_mem_lane_align.sv - big-endian store-lane merge and load extract/extend
module wb_mem_lane_align
  import wb_mem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] st_data,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] wr_word,
  output logic [31:0] ld_data
);
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Halves use only offset[1] and words ignore the offset, so align-down is implicit here.
  always_comb begin
    wr_word  = rd_word;
    ld_data  = rd_word;
    sel_byte = 8'h00;
    sel_half = 16'h0000;
    case (size)
      SIZE_BYTE: begin
        case (offset)
          2'd0:    begin sel_byte = rd_word[31:24]; wr_word[31:24] = st_data[7:0]; end
          2'd1:    begin sel_byte = rd_word[23:16]; wr_word[23:16] = st_data[7:0]; end
          2'd2:    begin sel_byte = rd_word[15:8];  wr_word[15:8]  = st_data[7:0]; end
          default: begin sel_byte = rd_word[7:0];   wr_word[7:0]   = st_data[7:0]; end
        endcase
        ld_data = {{24{sign_ext & sel_byte[7]}}, sel_byte};
      end
      SIZE_HALF: begin
        if (offset[1]) begin
          sel_half      = rd_word[15:0];
          wr_word[15:0] = st_data[15:0];
        end else begin
          sel_half       = rd_word[31:16];
          wr_word[31:16] = st_data[15:0];
        end
        ld_data = {{16{sign_ext & sel_half[15]}}, sel_half};
      end
      default: begin
        wr_word = st_data;
        ld_data = rd_word;
      end
    endcase
  end
endmodule

// File: rtl/wb_data_memory_ctrl.sv
// rtl/wb_data_memory_ctrl.sv - wait-stated byte/half/word data memory; DATAMEM_ALIGN_TRAP_EN enables misalignment faults
module wb_data_memory_ctrl
  import wb_mem_pkg::*;
#(
  parameter int DATAWIDTH_BUS   = 32,
  parameter int MEM_DEPTH_WORDS = 256,
  parameter int WAIT_STATES     = 2,
  parameter int ADDR_IDX_W      = $clog2(MEM_DEPTH_WORDS)
) (
  input logic                  DataMemCtrl_CLOCK_50,
  input logic                  DataMemCtrl_Reset_InLow,
  wb_data_memory_ctrl_if.slave bus
);
  localparam int AW = ADDR_IDX_W + 2;

  state_e                   state;
  logic [WAIT_W-1:0]        cnt;
  logic                     wr_q;
  logic                     sign_q;
  logic [1:0]               size_q;
  logic [AW-1:0]            addr_q;
  logic [31:0]              data_q;
  logic                     ack_q;
  logic                     busy_q;
  logic                     fault_q;
  logic [DATAWIDTH_BUS-1:0] data_out_q;
  logic [31:0]              mem [MEM_DEPTH_WORDS];
  logic [31:0]              rd_word;
  logic [31:0]              wr_word;
  logic [31:0]              ld_data;
  logic                     misaligned;
  logic                     commit;
  logic                     unused_addr;

  assign unused_addr = ^bus.DataMemCtrl_Address_In[DATAWIDTH_BUS-1:AW];
  assign rd_word     = mem[addr_q[AW-1:2]];
  assign commit      = (state == ST_ACCESS) && (cnt == '0);

`ifdef DATAMEM_ALIGN_TRAP_EN
  assign misaligned = ((size_q == SIZE_HALF) && addr_q[0]) ||
                      (size_q[1] && (addr_q[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  wb_mem_lane_align u_lane (
    .rd_word  (rd_word),
    .st_data  (data_q),
    .offset   (addr_q[1:0]),
    .size     (size_q),
    .sign_ext (sign_q),
    .wr_word  (wr_word),
    .ld_data  (ld_data)
  );

  // Gated by reset so an access abandoned by reset never reaches the array.
  always_ff @(posedge DataMemCtrl_CLOCK_50) begin
    if (DataMemCtrl_Reset_InLow && commit && wr_q && !misaligned)
      mem[addr_q[AW-1:2]] <= wr_word;
  end

  always_ff @(posedge DataMemCtrl_CLOCK_50) begin
    if (!DataMemCtrl_Reset_InLow) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      wr_q       <= 1'b0;
      sign_q     <= 1'b0;
      size_q     <= SIZE_BYTE;
      addr_q     <= '0;
      data_q     <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
      data_out_q <= '0;
    end else begin
      ack_q   <= 1'b0;
      fault_q <= 1'b0;
      case (state)
        ST_ACCESS: begin
          if (cnt == '0) begin
            state   <= ST_RESP;
            busy_q  <= 1'b0;
            ack_q   <= 1'b1;
            fault_q <= misaligned;
            if (!wr_q && !misaligned)
              data_out_q <= DATAWIDTH_BUS'(ld_data);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          if (bus.DataMemCtrl_Req_In) begin
            wr_q   <= bus.DataMemCtrl_WR_In;
            size_q <= bus.DataMemCtrl_Size_In;
            sign_q <= bus.DataMemCtrl_Signed_In;
            addr_q <= bus.DataMemCtrl_Address_In[AW-1:0];
            data_q <= bus.DataMemCtrl_Data_In[31:0];
            cnt    <= WAIT_W'(WAIT_STATES);
            busy_q <= 1'b1;
            state  <= ST_ACCESS;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.DataMemCtrl_Data_Out  = data_out_q;
  assign bus.DataMemCtrl_Ack_Out   = ack_q;
  assign bus.DataMemCtrl_Busy_Out  = busy_q;
  assign bus.DataMemCtrl_Fault_Out = fault_q;
endmodule

// File: tb/tb_wb_data_memory_ctrl.sv
// tb/tb_wb_data_memory_ctrl.sv - self-checking bench: directed table, back-to-back, busy drop, reset abort, random vs byte model
module tb_wb_data_memory_ctrl;
  localparam int W     = 2;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  wb_data_memory_ctrl_if #(.DATAWIDTH_BUS(32)) bus ();

  wb_data_memory_ctrl #(
    .DATAWIDTH_BUS(32), .MEM_DEPTH_WORDS(DEPTH), .WAIT_STATES(W)
  ) dut (
    .DataMemCtrl_CLOCK_50(clk),
    .DataMemCtrl_Reset_InLow(resetn),
    .bus(bus)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_fault;
  } vec_t;

  vec_t        vecs[11];
  logic [31:0] ref_mem[DEPTH];
  logic [31:0] exp_dout;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Memory seen as big-endian bytes: byte k of word w sits at bits [31-8k -: 8].
  task automatic model_op(input logic wr, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] data, output logic fault);
    int nb, idx, pos, sh;
    logic [31:0] a, v;
    logic [7:0] b;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    fault = 1'b0;
    a = addr - (addr % nb);
`ifdef DATAMEM_ALIGN_TRAP_EN
    if (a != addr) begin
      fault = 1'b1;
      return;
    end
`endif
    idx = int'((a / 4) % DEPTH);
    v = 32'h0;
    for (int k = 0; k < nb; k++) begin
      pos = int'(a % 4) + k;
      sh  = 8 * (3 - pos);
      if (wr) begin
        b = 8'((data >> (8 * (nb - 1 - k))) & 32'hFF);
        ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << sh)) | ({24'h0, b} << sh);
      end else begin
        v = (v << 8) | ((ref_mem[idx] >> sh) & 32'hFF);
      end
    end
    if (!wr) begin
      if (nb < 4 && sgn && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      exp_dout = v;
    end
  endtask

  task automatic drive(input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] data);
    bus.DataMemCtrl_WR_In      = wr;
    bus.DataMemCtrl_Size_In    = size;
    bus.DataMemCtrl_Signed_In  = sgn;
    bus.DataMemCtrl_Address_In = addr;
    bus.DataMemCtrl_Data_In    = data;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (!bus.DataMemCtrl_Ack_Out && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // One access from IDLE; inputs are scrambled right after acceptance.
  task automatic do_access(input logic wr, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] data, input string name,
                           output logic [31:0] got_data, output logic got_fault);
    int n, nbusy;
    drive(wr, size, sgn, addr, data);
    bus.DataMemCtrl_Req_In = 1'b1;
    @(posedge clk); #1;
    bus.DataMemCtrl_Req_In = 1'b0;
    drive(1'b1, 2'($urandom), 1'($urandom), $urandom, $urandom);
    n = 0;
    nbusy = bus.DataMemCtrl_Busy_Out ? 1 : 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (bus.DataMemCtrl_Ack_Out) break;
      if (bus.DataMemCtrl_Busy_Out) nbusy++;
    end
    check({name, " latency"}, n, W + 1);
    check({name, " busy cycles"}, nbusy, W + 1);
    got_data  = bus.DataMemCtrl_Data_Out;
    got_fault = bus.DataMemCtrl_Fault_Out;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] gd;
    logic        gf, ef;
    logic [31:0] a;
    int          n, acks;
    logic        trap;
`ifdef DATAMEM_ALIGN_TRAP_EN
    trap = 1'b1;
`else
    trap = 1'b0;
`endif
    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h11,  32'hAAAAAA7F, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h13,  32'h0,        32'hFFFFFFEF, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 32'h11,  32'h0,        32'h0000007F, 1'b0};
    vecs[5]  = '{1'b0, 2'd1, 1'b1, 32'h12,  32'h0,        32'hFFFFBEEF, 1'b0};
    vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h410, 32'h0,        32'hDE7FBEEF, 1'b0};
    vecs[7]  = '{1'b1, 2'd2, 1'b0, 32'h12,  32'h11111111, 32'hDE7FBEEF, trap};
    vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0, trap ? 32'hDE7FBEEF : 32'h11111111, 1'b0};
    vecs[9]  = '{1'b0, 2'd1, 1'b0, 32'h11,  32'h0, trap ? 32'hDE7FBEEF : 32'h00001111, trap};
    vecs[10] = '{1'b0, 2'd3, 1'b1, 32'h10,  32'h0, trap ? 32'hDE7FBEEF : 32'h11111111, 1'b0};

    bus.DataMemCtrl_Req_In = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ack", bus.DataMemCtrl_Ack_Out, 0);
    check("reset busy", bus.DataMemCtrl_Busy_Out, 0);
    check("reset fault", bus.DataMemCtrl_Fault_Out, 0);
    check("reset data", bus.DataMemCtrl_Data_Out, 0);
    resetn = 1'b1;
    exp_dout = 32'h0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      model_op(vecs[i].wr, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].data, ef);
      do_access(vecs[i].wr, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].data,
                $sformatf("vec%0d", i), gd, gf);
      check($sformatf("vec%0d data", i), gd, vecs[i].exp_data);
      check($sformatf("vec%0d fault", i), gf, vecs[i].exp_fault);
    end

    // Random phase: seed words 0..15, then mixed accesses with random upper address bits.
    for (int i = 0; i < 16; i++) begin
      a = 32'(i * 4);
      gd = $urandom;
      model_op(1'b1, 2'd2, 1'b0, a, gd, ef);
      do_access(1'b1, 2'd2, 1'b0, a, gd, "seed", gd, gf);
    end
    for (int i = 0; i < 40; i++) begin
      logic        wr, sgn;
      logic [1:0]  sz;
      logic [31:0] d;
      wr  = 1'($urandom);
      sz  = 2'($urandom);
      sgn = 1'($urandom);
      a   = $urandom & ~32'h3C0;
      d   = $urandom;
      model_op(wr, sz, sgn, a, d, ef);
      do_access(wr, sz, sgn, a, d, $sformatf("rnd%0d", i), gd, gf);
      check($sformatf("rnd%0d data a=%h sz=%0d", i, a, sz), gd, exp_dout);
      check($sformatf("rnd%0d fault", i), gf, ef);
    end

    // Req held through RESP: second load accepted on the RESP edge.
    model_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, ef);
    drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    bus.DataMemCtrl_Req_In = 1'b1;
    @(posedge clk); #1;
    wait_ack(n);
    check("b2b first latency", n, W + 1);
    check("b2b first data", bus.DataMemCtrl_Data_Out, exp_dout);
    drive(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
    model_op(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, ef);
    @(posedge clk); #1;
    check("b2b accepted busy", bus.DataMemCtrl_Busy_Out, 1);
    check("b2b ack single", bus.DataMemCtrl_Ack_Out, 0);
    bus.DataMemCtrl_Req_In = 1'b0;
    wait_ack(n);
    check("b2b second latency", n, W + 1);
    check("b2b second data", bus.DataMemCtrl_Data_Out, exp_dout);
    @(posedge clk); #1;

    // Req pulsed while busy (a store) must be dropped.
    model_op(1'b0, 2'd2, 1'b0, 32'h18, 32'h0, ef);
    drive(1'b0, 2'd2, 1'b0, 32'h18, 32'h0);
    bus.DataMemCtrl_Req_In = 1'b1;
    @(posedge clk); #1;
    bus.DataMemCtrl_Req_In = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, 2'd2, 1'b0, 32'h1C, 32'hBADC0DE5);
    bus.DataMemCtrl_Req_In = 1'b1;
    @(posedge clk); #1;
    bus.DataMemCtrl_Req_In = 1'b0;
    wait_ack(n);
    check("busy-drop first data", bus.DataMemCtrl_Data_Out, exp_dout);
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.DataMemCtrl_Ack_Out) acks++;
    end
    check("busy-drop extra acks", acks, 0);
    model_op(1'b0, 2'd2, 1'b0, 32'h1C, 32'h0, ef);
    do_access(1'b0, 2'd2, 1'b0, 32'h1C, 32'h0, "busy-drop readback", gd, gf);
    check("busy-drop readback data", gd, exp_dout);

    // Reset during ACCESS abandons the store.
    drive(1'b1, 2'd2, 1'b0, 32'h10, 32'h0);
    bus.DataMemCtrl_Req_In = 1'b1;
    @(posedge clk); #1;
    bus.DataMemCtrl_Req_In = 1'b0;
    check("abort busy", bus.DataMemCtrl_Busy_Out, 1);
    resetn = 1'b0;
    acks = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.DataMemCtrl_Ack_Out) acks++;
    end
    resetn = 1'b1;
    exp_dout = 32'h0;
    check("abort busy after reset", bus.DataMemCtrl_Busy_Out, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.DataMemCtrl_Ack_Out) acks++;
    end
    check("abort no ack", acks, 0);
    model_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, ef);
    do_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "abort readback", gd, gf);
    check("abort readback data", gd, exp_dout);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
